// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one INCR burst at a time from a single-port word SRAM.
// Write channel has priority; unsupported or out-of-range bursts return SLVERR/DECERR.
module axi_sram_slave #(
   parameter int          MEM_ADDR_BIT = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              arid,
   input  logic [31:0]             araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic [1:0]              arlock,
   input  logic [3:0]              arcache,
   input  logic [2:0]              arprot,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [3:0]              rid,
   output logic [31:0]             rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready,
   input  logic [3:0]              awid,
   input  logic [31:0]             awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic [1:0]              awlock,
   input  logic [3:0]              awcache,
   input  logic [2:0]              awprot,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [3:0]              wid,
   input  logic [31:0]             wdata,
   input  logic [3:0]              wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [3:0]              bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   output logic                    mem_en,
   output logic [3:0]              mem_wen,
   output logic [MEM_ADDR_BIT-1:0] mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_DATA, S_WR_DATA, S_WR_RESP, S_WR_DRAIN
   } state_t;

   localparam logic [1:0]  OKAY    = 2'b00;
   localparam logic [1:0]  SLVERR  = 2'b10;
   localparam logic [1:0]  DECERR  = 2'b11;
   localparam logic [30:0] C_WORDS = 31'd1 << MEM_ADDR_BIT;

   state_t                  r_state;
   state_t                  w_next;
   logic [3:0]              r_id;
   logic [MEM_ADDR_BIT-1:0] r_addr;
   logic [7:0]              r_len;
   logic [7:0]              r_beat;
   logic [1:0]              r_err;
   logic [1:0]              r_bresp;

   logic [3:0]  w_id;
   logic [31:0] w_addr;
   logic [7:0]  w_len;
   logic [2:0]  w_size;
   logic [1:0]  w_burst;
   logic [30:0] w_off;
   logic [30:0] w_end;
   logic [1:0]  w_err;
   logic        w_aw_acc;
   logic        w_ar_acc;
   logic        w_rd_step;
   logic        w_wr_step;
   logic        w_unused;

   assign w_id    = awvalid ? awid    : arid;
   assign w_addr  = awvalid ? awaddr  : araddr;
   assign w_len   = awvalid ? awlen   : arlen;
   assign w_size  = awvalid ? awsize  : arsize;
   assign w_burst = awvalid ? awburst : arburst;

   // Word offset from the SRAM base; bit 30 set means the start lies below it.
   assign w_off = {1'b0, w_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
   assign w_end = {1'b0, w_off[29:0]} + {23'd0, w_len};
   assign w_err = (w_off[30] || w_end >= C_WORDS) ? DECERR :
                  (w_size != 3'b010 || w_burst != 2'b01) ? SLVERR : OKAY;

   assign w_aw_acc  = awvalid && awready;
   assign w_ar_acc  = arvalid && arready;
   assign w_rd_step = (r_state == S_RD_DATA) && rready;
   assign w_wr_step = (r_state == S_WR_DATA) && wvalid;

   assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot,
                       wid, w_addr[1:0], w_off[29:MEM_ADDR_BIT]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_err   <= OKAY;
         r_bresp <= OKAY;
      end else if (w_aw_acc || w_ar_acc) begin
         r_id    <= w_id;
         r_addr  <= w_off[MEM_ADDR_BIT-1:0];
         r_len   <= w_len;
         r_beat  <= '0;
         r_err   <= w_err;
         r_bresp <= w_aw_acc ? w_err : OKAY;
      end else if (w_rd_step || w_wr_step) begin
         r_addr <= r_addr + MEM_ADDR_BIT'(1);
         r_beat <= r_beat + 8'd1;
         // Overrun beats and an early wlast both make the burst a slave error.
         if (w_wr_step && (r_beat > r_len || (wlast && r_beat != r_len)))
            r_bresp <= SLVERR;
      end
   end

   always_comb begin
      w_next    = r_state;
      arready   = 1'b0;
      awready   = 1'b0;
      wready    = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      rid       = '0;
      rdata     = '0;
      rresp     = OKAY;
      bvalid    = 1'b0;
      bid       = '0;
      bresp     = OKAY;
      mem_en    = 1'b0;
      mem_wen   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (!rst) begin
               awready = 1'b1;
               arready = !awvalid;
               if (awvalid)
                  w_next = (w_err == OKAY) ? S_WR_DATA : S_WR_DRAIN;
               else if (arvalid)
                  w_next = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            mem_en   = (r_err == OKAY);
            mem_addr = r_addr;
            w_next   = S_RD_DATA;
         end
         S_RD_DATA: begin
            rvalid = 1'b1;
            rid    = r_id;
            rdata  = (r_err == OKAY) ? mem_rdata : '0;
            rresp  = r_err;
            rlast  = (r_beat == r_len);
            if (rready)
               w_next = rlast ? S_IDLE : S_RD_REQ;
         end
         S_WR_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               if (r_beat <= r_len && wstrb != 4'h0) begin
                  mem_en    = 1'b1;
                  mem_wen   = wstrb;
                  mem_addr  = r_addr;
                  mem_wdata = wdata;
               end
               if (wlast) w_next = S_WR_RESP;
            end
         end
         S_WR_DRAIN: begin
            wready = 1'b1;
            if (wvalid && wlast) w_next = S_WR_RESP;
         end
         S_WR_RESP: begin
            bvalid = 1'b1;
            bid    = r_id;
            bresp  = r_bresp;
            if (bready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
